// File: rtl/usb_rw_pkg.sv
// Shared types and constants for the USB read/write transaction sequencer.
// WDOG_CYCLES is only used when USB_RW_WDOG_EN is defined.
package usb_rw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_ISSUE,
    A_WAIT,
    D_ISSUE,
    D_WAIT,
    RESP
  } sched_state_t;

  localparam logic [3:0] PID_OUT     = 4'b1000;
  localparam logic [3:0] PID_IN      = 4'b1001;
  localparam logic [7:0] PID_DATA0   = 8'hC3;
  localparam int         WDOG_CYCLES = 4096;

  function automatic logic [18:0] mk_token(input logic [3:0] pid,
                                           input logic [6:0] addr,
                                           input logic [3:0] ep);
    return {pid, addr, ep, 4'b0000};
  endfunction

endpackage

// File: rtl/usb_rw_sched_rr_arb2.sv
// Two-way round-robin arbiter: when both request, the one not granted last wins.
// The priority pointer only moves when a grant is actually accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // Point at the requester that was not just served.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant[1];
    end
  end

endmodule

// File: rtl/usb_rw_sched.sv
// Sequencer turning host READ/WRITE requests into address + data protocol transactions.
// Optional USB_RW_WDOG_EN adds a per-transaction watchdog that aborts a hung wait phase.
module usb_rw_sched #(
  parameter logic [6:0] DEV_ADDR = 7'd5,
  parameter logic [3:0] ADDR_EP  = 4'd4,
  parameter logic [3:0] DATA_EP  = 4'd8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [1:0]   req_valid,
  input  logic [1:0]   req_write,
  input  logic [31:0]  req_page,
  input  logic [127:0] req_wdata,
  output logic [1:0]   req_ready,
  output logic         resp_valid,
  output logic         resp_id,
  output logic         resp_ok,
  output logic [63:0]  resp_rdata,
  output logic [18:0]  tokenRW,
  output logic [71:0]  dataRW,
  output logic         pktInAvailRW,
  input  logic         readyIn,
  input  logic         done,
  input  logic         success,
  input  logic [63:0]  dataOut
);

  import usb_rw_pkg::*;

  sched_state_t state, next_state;
  logic [1:0]   grant;
  logic         accept;
  logic         issue;
  logic         finish;
  logic         fin_ok;
  logic         wdog_hit;
  logic         op_write;
  logic         op_id;
  logic [15:0]  op_page;
  logic [63:0]  op_wdata;

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_b  (rst_b),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    finish     = 1'b0;
    fin_ok     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = A_ISSUE;
      end
      A_ISSUE: begin
        if (readyIn) begin
          issue      = 1'b1;
          next_state = A_WAIT;
        end
      end
      A_WAIT: begin
        if (done && success) begin
          next_state = D_ISSUE;
        end else if (done || wdog_hit) begin
          finish     = 1'b1;
          next_state = RESP;
        end
      end
      D_ISSUE: begin
        if (readyIn) begin
          issue      = 1'b1;
          next_state = D_WAIT;
        end
      end
      D_WAIT: begin
        if (done || wdog_hit) begin
          finish     = 1'b1;
          fin_ok     = done && success;
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch, protocol issue registers and response registers; token/data hold between issues.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_write     <= 1'b0;
      op_id        <= 1'b0;
      op_page      <= '0;
      op_wdata     <= '0;
      tokenRW      <= '0;
      dataRW       <= '0;
      pktInAvailRW <= 1'b0;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_ok      <= 1'b0;
      resp_rdata   <= '0;
    end else begin
      pktInAvailRW <= 1'b0;
      resp_valid   <= 1'b0;
      if (accept) begin
        op_id    <= grant[1];
        op_write <= grant[1] ? req_write[1]       : req_write[0];
        op_page  <= grant[1] ? req_page[31:16]    : req_page[15:0];
        op_wdata <= grant[1] ? req_wdata[127:64]  : req_wdata[63:0];
      end
      if (issue) begin
        pktInAvailRW <= 1'b1;
        if (state == A_ISSUE) begin
          tokenRW <= mk_token(PID_OUT, DEV_ADDR, ADDR_EP);
          dataRW  <= {PID_DATA0, op_page, 48'd0};
        end else if (op_write) begin
          tokenRW <= mk_token(PID_OUT, DEV_ADDR, DATA_EP);
          dataRW  <= {PID_DATA0, op_wdata};
        end else begin
          tokenRW <= mk_token(PID_IN, DEV_ADDR, DATA_EP);
          dataRW  <= '0;
        end
      end
      if (finish) begin
        resp_valid <= 1'b1;
        resp_id    <= op_id;
        resp_ok    <= fin_ok;
        resp_rdata <= (fin_ok && !op_write) ? dataOut : 64'd0;
      end
    end
  end

`ifdef USB_RW_WDOG_EN
  logic [15:0] wdog_cnt;

  // Restarted by every issue strobe so each protocol transaction gets its own budget.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wdog_cnt <= '0;
    end else if (issue) begin
      wdog_cnt <= '0;
    end else if (state == A_WAIT || state == D_WAIT) begin
      wdog_cnt <= wdog_cnt + 16'd1;
    end
  end

  assign wdog_hit = (wdog_cnt == 16'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rw_sched.sv
// Self-checking bench for usb_rw_sched: directed scenarios with randomized payloads,
// a reactive protocol model and a request-level reference model of expected responses.
module tb_usb_rw_sched;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_write = '0;
  logic [31:0]  req_page = '0;
  logic [127:0] req_wdata = '0;
  logic [1:0]   req_ready;
  logic         resp_valid;
  logic         resp_id;
  logic         resp_ok;
  logic [63:0]  resp_rdata;
  logic [18:0]  tokenRW;
  logic [71:0]  dataRW;
  logic         pktInAvailRW;
  logic         readyIn = 1'b1;
  logic         done = 1'b0;
  logic         success = 1'b0;
  logic [63:0]  dataOut = '0;

  int    total = 0;
  int    bad = 0;
  string cur_test = "reset";

  // protocol model knobs and record of issued transactions
  int          pm_delay = 1;
  logic        pm_fail_addr = 1'b0;
  logic        pm_fail_data = 1'b0;
  logic        pm_silent_data = 1'b0;
  logic [63:0] pm_rdata = '0;
  logic [18:0] tok_q[$];
  logic [71:0] dat_q[$];

  // reference arbitration state: requester served most recently
  int last_grant = 1;

  usb_rw_sched dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_page     (req_page),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_ok      (resp_ok),
    .resp_rdata   (resp_rdata),
    .tokenRW      (tokenRW),
    .dataRW       (dataRW),
    .pktInAvailRW (pktInAvailRW),
    .readyIn      (readyIn),
    .done         (done),
    .success      (success),
    .dataOut      (dataOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s/%s observed=%0h expected=%0h", cur_test, tag, obs, exp);
    end
  endtask

  // Protocol responder: records each issue, answers after pm_delay cycles, checks hold-stability.
  initial begin : proto_model
    logic [18:0] t;
    logic [71:0] d;
    logic        is_addr;
    forever begin
      @(posedge clk);
      #1;
      if (rst_b && pktInAvailRW) begin
        t = tokenRW;
        d = dataRW;
        tok_q.push_back(t);
        dat_q.push_back(d);
        is_addr = (t[7:4] == 4'd4);
        if (is_addr || !pm_silent_data) begin
          repeat (pm_delay) begin
            @(posedge clk);
            #1;
          end
          done    = 1'b1;
          success = is_addr ? !pm_fail_addr : !pm_fail_data;
          dataOut = pm_rdata;
          checkOutput("tok_stable", tokenRW, t);
          checkOutput("dat_stable", dataRW, d);
          @(posedge clk);
          #1;
          done    = 1'b0;
          success = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input int id, input logic wr, input logic [15:0] page,
                               input logic [63:0] wdata);
    int n = 0;
    @(negedge clk);
    req_write[id]          = wr;
    req_page[id*16 +: 16]  = page;
    req_wdata[id*64 +: 64] = wdata;
    req_valid[id]          = 1'b1;
    #1;
    while (req_ready == 2'b00 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("grant", req_ready, 72'(2'b01 << id));
    last_grant = id;
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic waitResp(input logic eid, input logic eok, input logic [63:0] erd, input int budget);
    int   n = 0;
    logic seen;
    while (!resp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    seen = resp_valid;
    checkOutput("resp_seen", seen, 1);
    if (seen) begin
      checkOutput("resp_id", resp_id, eid);
      checkOutput("resp_ok", resp_ok, eok);
      checkOutput("resp_rdata", resp_rdata, erd);
      checkOutput("ready_in_resp", req_ready, 0);
    end
    @(negedge clk);
    checkOutput("resp_one_cycle", resp_valid, 0);
  endtask

  task automatic checkTokens(input logic wr, input logic [15:0] page, input logic [63:0] wdata,
                             input logic addr_fail);
    logic [18:0] et1;
    logic [71:0] ed1;
    et1 = wr ? {4'b1000, 7'd5, 4'd8, 4'd0} : {4'b1001, 7'd5, 4'd8, 4'd0};
    ed1 = wr ? {8'hC3, wdata} : 72'd0;
    checkOutput("n_issues", tok_q.size(), addr_fail ? 1 : 2);
    if (tok_q.size() >= 1) begin
      checkOutput("addr_token", tok_q[0], {4'b1000, 7'd5, 4'd4, 4'd0});
      checkOutput("addr_data", dat_q[0], {8'hC3, page, 48'd0});
    end
    if (tok_q.size() >= 2) begin
      checkOutput("data_token", tok_q[1], et1);
      checkOutput("data_data", dat_q[1], ed1);
    end
    tok_q.delete();
    dat_q.delete();
  endtask

  task automatic doReq(input int id, input logic wr, input logic [15:0] page, input logic [63:0] wdata);
    logic        eok;
    logic [63:0] erd;
    applyStimulus(id, wr, page, wdata);
    eok = !(pm_fail_addr || pm_fail_data);
    erd = (!wr && eok) ? pm_rdata : 64'd0;
    waitResp(id[0], eok, erd, 200);
    checkTokens(wr, page, wdata, pm_fail_addr);
  endtask

  task automatic checkAllZero();
    checkOutput("z_req_ready", req_ready, 0);
    checkOutput("z_resp_valid", resp_valid, 0);
    checkOutput("z_resp_id", resp_id, 0);
    checkOutput("z_resp_ok", resp_ok, 0);
    checkOutput("z_resp_rdata", resp_rdata, 0);
    checkOutput("z_token", tokenRW, 0);
    checkOutput("z_data", dataRW, 0);
    checkOutput("z_pkt", pktInAvailRW, 0);
  endtask

  initial begin
    logic        wr;
    logic [15:0] pg;
    logic [63:0] wd;
    int          eg;
    int          n;
    int          strobes;
    int          resp_seen;

    repeat (3) @(negedge clk);
    checkAllZero();
    rst_b = 1'b1;

    cur_test = "t1_write";
    pm_rdata = {$urandom, $urandom};
    doReq(0, 1'b1, 16'h1234, 64'hDEAD_BEEF_0000_0001);

    cur_test = "t2_read";
    pm_rdata = 64'hA5A5_0F0F_1234_5678;
    doReq(1, 1'b0, 16'h0040, 64'd0);

    cur_test = "t3_rr";
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      req_write[r]          = 1'($urandom);
      req_page[r*16 +: 16]  = 16'($urandom);
      req_wdata[r*64 +: 64] = {$urandom, $urandom};
    end
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      pm_rdata = {$urandom, $urandom};
      pm_delay = $urandom_range(0, 3);
      n = 0;
      #1;
      while (req_ready == 2'b00 && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
      eg = (last_grant == 0) ? 1 : 0;
      checkOutput("rr_grant", req_ready, 72'(2'b01 << eg));
      wr = req_write[eg];
      pg = req_page[eg*16 +: 16];
      wd = req_wdata[eg*64 +: 64];
      last_grant = eg;
      @(negedge clk);
      req_write[eg]          = 1'($urandom);
      req_page[eg*16 +: 16]  = 16'($urandom);
      req_wdata[eg*64 +: 64] = {$urandom, $urandom};
      waitResp(eg[0], 1'b1, wr ? 64'd0 : pm_rdata, 200);
      checkTokens(wr, pg, wd, 1'b0);
    end
    req_valid = 2'b00;

    cur_test = "t4_addr_fail";
    pm_delay     = 1;
    pm_fail_addr = 1'b1;
    pm_rdata     = {$urandom, $urandom};
    doReq(0, 1'b0, 16'($urandom), 64'd0);
    pm_fail_addr = 1'b0;

    cur_test = "t4b_data_fail";
    pm_fail_data = 1'b1;
    pm_rdata     = {$urandom, $urandom};
    doReq(1, 1'b0, 16'($urandom), 64'd0);
    pm_fail_data = 1'b0;

    cur_test = "t5_stall";
    pm_delay = 2;
    pg = 16'($urandom);
    wd = {$urandom, $urandom};
    applyStimulus(1, 1'b1, pg, wd);
    n = 0;
    while (tok_q.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    readyIn = 1'b0;
    strobes = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pktInAvailRW) strobes++;
    end
    checkOutput("stall_strobes", strobes, 0);
    checkOutput("stall_token", tokenRW, {4'b1000, 7'd5, 4'd4, 4'd0});
    checkOutput("stall_data", dataRW, {8'hC3, pg, 48'd0});
    readyIn = 1'b1;
    @(negedge clk);
    checkOutput("strobe_on_ready", pktInAvailRW, 1);
    waitResp(1'b1, 1'b1, 64'd0, 200);
    checkTokens(1'b1, pg, wd, 1'b0);

    cur_test = "t6_reset";
    pm_delay       = 1;
    pm_silent_data = 1'b1;
    applyStimulus(0, 1'($urandom), 16'($urandom), {$urandom, $urandom});
    n = 0;
    while (tok_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_d_wait", tok_q.size(), 2);
    rst_b = 1'b0;
    #1;
    checkAllZero();
    resp_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    rst_b = 1'b1;
    last_grant = 1;
    pm_silent_data = 1'b0;
    tok_q.delete();
    dat_q.delete();
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    checkOutput("no_resp_after_reset", resp_seen, 0);
    for (int r = 0; r < 2; r++) begin
      req_write[r]          = 1'($urandom);
      req_page[r*16 +: 16]  = 16'($urandom);
      req_wdata[r*64 +: 64] = {$urandom, $urandom};
    end
    pm_rdata  = {$urandom, $urandom};
    req_valid = 2'b11;
    #1;
    checkOutput("grant_after_reset", req_ready, 2'b01);
    wr = req_write[0];
    pg = req_page[15:0];
    wd = req_wdata[63:0];
    last_grant = 0;
    @(negedge clk);
    req_valid = 2'b00;
    waitResp(1'b0, 1'b1, wr ? 64'd0 : pm_rdata, 200);
    checkTokens(wr, pg, wd, 1'b0);

`ifdef USB_RW_WDOG_EN
    cur_test = "t7_wdog";
    pm_silent_data = 1'b1;
    pm_rdata = {$urandom, $urandom};
    pg = 16'($urandom);
    applyStimulus(1, 1'b0, pg, 64'd0);
    waitResp(1'b1, 1'b0, 64'd0, 6000);
    checkTokens(1'b0, pg, 64'd0, 1'b0);
    pm_silent_data = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
